// File: rtl/spi_slave_tx_if.sv
// Local word handshake plus SPI pins of the peripheral-side transmitter.
// The slave modport is the transmitter's view; master is the source/SPI-master side.
interface spi_slave_tx_if #(
  parameter int WIDTH = 16
);
  logic             sck_i;
  logic             cs_i;
  logic             sdo_o;
  logic             sdo_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             frame_done;
  logic             frame_abort;
  logic             underrun;

  modport slave (
    input  sck_i, cs_i, tx_data, tx_valid,
    output sdo_o, sdo_oe, tx_ready, frame_done, frame_abort, underrun
  );

  modport master (
    output sck_i, cs_i, tx_data, tx_valid,
    input  sdo_o, sdo_oe, tx_ready, frame_done, frame_abort, underrun
  );
endinterface

// File: rtl/spi_slave_tx.sv
// SPI peripheral transmitter: buffers one word from a valid/ready source and
// shifts it out MSB-first while the master holds cs low; sck/cs are oversampled.
module spi_slave_tx #(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
  input logic           clk,
  input logic           rst,
  spi_slave_tx_if.slave bus
);
  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic                   sck_hist_reg;
  logic                   cs_hist_reg;
  logic                   sck_s;
  logic                   cs_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_fall;
  logic                   cs_rise;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic             sdo_reg, sdo_next;
  logic             oe_reg, oe_next;
  logic             done_reg, done_next;
  logic             abort_reg, abort_next;
  logic             underrun_reg, underrun_next;
  logic             accept;

  // Synchronizer chains plus one history flop each; idle levels are sck=0, cs=1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync_reg <= '0;
      cs_sync_reg  <= '1;
      sck_hist_reg <= 1'b0;
      cs_hist_reg  <= 1'b1;
    end else begin
      if (SYNC_STAGES > 1) begin
        sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], bus.sck_i};
        cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], bus.cs_i};
      end else begin
        sck_sync_reg <= {SYNC_STAGES{bus.sck_i}};
        cs_sync_reg  <= {SYNC_STAGES{bus.cs_i}};
      end
      sck_hist_reg <= sck_s;
      cs_hist_reg  <= cs_s;
    end
  end

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist_reg;
  assign sck_fall = ~sck_s & sck_hist_reg;
  assign cs_fall  = ~cs_s & cs_hist_reg;
  assign cs_rise  = cs_s & ~cs_hist_reg;

  assign accept = bus.tx_valid & ~hold_full_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      sdo_reg       <= 1'b0;
      oe_reg        <= 1'b0;
      done_reg      <= 1'b0;
      abort_reg     <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      sdo_reg       <= sdo_next;
      oe_reg        <= oe_next;
      done_reg      <= done_next;
      abort_reg     <= abort_next;
      underrun_reg  <= underrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    cnt_next       = cnt_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    sdo_next       = sdo_reg;
    oe_next        = oe_reg;
    done_next      = 1'b0;
    abort_next     = 1'b0;
    underrun_next  = 1'b0;

    // Accept only fills an empty holder and frame start only drains a full one,
    // so the two never collide; a same-cycle accept is kept for the next frame.
    if (accept) begin
      hold_next      = bus.tx_data;
      hold_full_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          if (hold_full_reg) begin
            shift_next     = hold_reg;
            hold_full_next = 1'b0;
          end else begin
            shift_next    = IDLE_WORD;
            underrun_next = 1'b1;
          end
          sdo_next   = shift_next[WIDTH-1];
          oe_next    = 1'b1;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort_next = 1'b1;
          oe_next    = 1'b0;
          sdo_next   = 1'b0;
          state_next = IDLE;
        end else if (sck_rise) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_next == LAST_BIT) begin
            done_next  = 1'b1;
            state_next = DONE;
          end
        end else if (sck_fall) begin
          shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          sdo_next   = shift_reg[WIDTH-2];
        end
      end
      DONE: begin
        if (cs_rise) begin
          oe_next    = 1'b0;
          sdo_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.sdo_o       = sdo_reg;
  assign bus.sdo_oe      = oe_reg;
  assign bus.tx_ready    = ~hold_full_reg;
  assign bus.frame_done  = done_reg;
  assign bus.frame_abort = abort_reg;
  assign bus.underrun    = underrun_reg;
endmodule

// File: tb/tb_spi_slave_tx.sv
// Scoreboard bench for spi_slave_tx: a word-level model predicts each frame's
// content and pulses; a monitor compares whenever the DUT ends a frame.
`timescale 1ns/1ps
module tb_spi_slave_tx;
  localparam int               WIDTH  = 16;
  localparam int               SYNC   = 2;
  localparam logic [WIDTH-1:0] IDLE_W = '0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_slave_tx_if #(.WIDTH(WIDTH)) bus();

  spi_slave_tx #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC),
    .IDLE_WORD(IDLE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [WIDTH-1:0] word;
    bit               underrun;
    int               nbits;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               failures = 0;
  bit               model_full = 1'b0;
  logic [WIDTH-1:0] model_word = '0;
  int               start_countdown = 0;
  int               pend_nbits = 0;
  int               acc_count = 0;
  logic [WIDTH-1:0] rx_word = '0;
  int               rx_n = 0;
  int               ur_seen = 0;
  bit               mon_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Word-level reference: one holding slot; a frame start takes the slot or the idle word.
  always @(posedge clk) begin
    if (!rst) begin
      model_full      = 1'b0;
      start_countdown = 0;
      exp_q.delete();
    end else begin : model_step
      bit   start;
      bit   acc;
      exp_t e;
      start = (start_countdown == 1);
      if (start_countdown > 0) start_countdown--;
      acc = bus.tx_valid && !model_full;
      if (start) begin
        e.nbits    = pend_nbits;
        e.underrun = !model_full;
        e.word     = model_full ? model_word : IDLE_W;
        exp_q.push_back(e);
        model_full = 1'b0;
      end
      if (acc) begin
        model_word = bus.tx_data;
        model_full = 1'b1;
        acc_count++;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      ur_seen = 0;
    end else if (mon_en) begin
      check("tx_ready", 32'(bus.tx_ready), 32'(!model_full));
      if (bus.underrun) ur_seen++;
      if (bus.frame_done || bus.frame_abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=done%0b/abort%0b required=none",
                   bus.frame_done, bus.frame_abort);
        end else begin
          e = exp_q.pop_front();
          check("frame_done_kind", 32'(bus.frame_done), 32'(e.nbits == WIDTH));
          check("frame_abort_kind", 32'(bus.frame_abort), 32'(e.nbits != WIDTH));
          check("frame_underrun", ur_seen, 32'(e.underrun));
          check("frame_bits", rx_n, e.nbits);
          check("frame_data", 32'(rx_word), 32'(e.word >> (WIDTH - e.nbits)));
        end
        ur_seen = 0;
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] w);
    int c0;
    c0 = acc_count;
    @(negedge clk);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 2000 && acc_count == c0; i++) @(negedge clk);
    check("send_accepted", 32'(acc_count != c0), 1);
    bus.tx_valid = 1'b0;
  endtask

  // SPI master: sck idle low, samples sdo at each rising pin edge.
  task automatic frame(input int nbits, input int ph, input bit keep_low);
    @(negedge clk);
    bus.cs_i        = 1'b0;
    rx_word         = '0;
    rx_n            = 0;
    pend_nbits      = nbits;
    start_countdown = SYNC + 1;
    repeat (ph) @(negedge clk);
    check("sdo_oe_active", 32'(bus.sdo_oe), 1);
    for (int i = 0; i < nbits; i++) begin
      rx_word = {rx_word[WIDTH-2:0], bus.sdo_o};
      rx_n++;
      bus.sck_i = 1'b1;
      repeat (ph) @(negedge clk);
      bus.sck_i = 1'b0;
      repeat (ph) @(negedge clk);
    end
    if (!keep_low) begin
      bus.cs_i = 1'b1;
      repeat (ph + 3) @(negedge clk);
      check("sdo_oe_idle", 32'(bus.sdo_oe), 0);
      check("sdo_idle", 32'(bus.sdo_o), 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sck_i    = 1'b0;
    bus.cs_i     = 1'b1;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sdo", 32'(bus.sdo_o), 0);
    check("rst_sdo_oe", 32'(bus.sdo_oe), 0);
    check("rst_tx_ready", 32'(bus.tx_ready), 1);
    check("rst_done", 32'(bus.frame_done), 0);
    check("rst_abort", 32'(bus.frame_abort), 0);
    check("rst_underrun", 32'(bus.underrun), 0);
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    send(16'h1EE0);
    frame(16, 6, 1'b0);
    check("t1_word", 32'(rx_word), 32'h1EE0);

    frame(16, 5, 1'b0);
    check("t2_idle_word", 32'(rx_word), 32'h0000);

    send(16'hA5A5);
    fork
      frame(16, 6, 1'b0);
      begin
        repeat (40) @(negedge clk);
        send(16'h0FF0);
      end
    join
    check("t3_first", 32'(rx_word), 32'hA5A5);
    frame(16, 7, 1'b0);
    check("t3_second", 32'(rx_word), 32'h0FF0);

    send(16'hC003);
    frame(5, 6, 1'b0);
    check("t4_partial", 32'(rx_word), 32'h18);
    frame(16, 5, 1'b0);

    send(16'h5A5A);
    frame(8, 6, 1'b1);
    @(negedge clk);
    rst       = 1'b0;
    bus.cs_i  = 1'b1;
    bus.sck_i = 1'b0;
    @(negedge clk);
    check("t5_sdo", 32'(bus.sdo_o), 0);
    check("t5_sdo_oe", 32'(bus.sdo_oe), 0);
    check("t5_tx_ready", 32'(bus.tx_ready), 1);
    check("t5_pulses", 32'({bus.frame_done, bus.frame_abort, bus.underrun}), 0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    send(16'h8001);
    frame(16, 6, 1'b0);
    check("t5_after_reset", 32'(rx_word), 32'h8001);

    fork
      frame(16, 6, 1'b0);
      begin
        repeat (SYNC) @(negedge clk);
        send(16'h1234);
      end
    join
    check("t6_first", 32'(rx_word), 32'h0000);
    frame(16, 6, 1'b0);
    check("t6_second", 32'(rx_word), 32'h1234);

    for (int it = 0; it < 30; it++) begin : rand_frames
      int ph;
      int nb;
      int mode;
      ph   = int'($urandom_range(5, 9));
      nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 1)) : WIDTH;
      mode = int'($urandom_range(0, 2));
      if (mode == 1 && !model_full) send(WIDTH'($urandom));
      if (mode == 2) begin
        fork
          frame(nb, ph, 1'b0);
          begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            send(WIDTH'($urandom));
          end
        join
      end else begin
        frame(nb, ph, 1'b0);
      end
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
